// File: rtl/sys_bus_pkg.sv
// ============================================================================
// Module  : sys_bus_pkg
// Purpose : Shared constants, FSM state encoding and a line-alignment helper
//           for the system bus arbiter and its round-robin sub-arbiter.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sys_bus_pkg;

  // Default cache-line geometry (64-byte lines).
  localparam int HMEM_LINE     = 512;
  localparam int HMEM_OFFS_LEN = 6;

  // Bus transaction FSM encoding.
  typedef enum logic [1:0] {
    SB_IDLE = 2'd0,
    SB_MEM  = 2'd1,
    SB_RESP = 2'd2
  } sb_state_t;

  // Clear the low 'offs' bits so the address names a whole line.
  function automatic logic [63:0] line_align(input logic [63:0] addr,
                                             input int          offs);
    line_align = addr & ~((64'd1 << offs) - 64'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sys_bus_rr_arb.sv
// ============================================================================
// Module  : rr_arb
// Purpose : N-way round-robin arbiter. Grant is combinational and one-hot;
//           the priority pointer (last-served index) only advances when
//           'update' is high and some request is present.
// Ports   : clk, rst_n  - clock, synchronous active-low reset
//           req [N]     - request vector
//           update      - commit the current grant (advance the pointer)
//           gnt [N]     - one-hot grant, zero when no request
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb
  import sys_bus_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         update,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic          found;

  // Two passes: first the harts strictly above the last-served index, then
  // wrap around to the low indices (including the last-served one itself).
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i > int'(ptr))) begin
        gnt[i]  = 1'b1;
        gnt_idx = PW'(i);
        found   = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i <= int'(ptr))) begin
        gnt[i]  = 1'b1;
        gnt_idx = PW'(i);
        found   = 1'b1;
      end
    end
  end

  // Reset pointer at the top index so index 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= PW'(N - 1);
    end else if (update && found) begin
      ptr <= gnt_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sys_bus.sv
// ============================================================================
// Module  : sys_bus
// Purpose : Shared system-bus arbiter between N_HARTS L2 ports and a single
//           main-memory port. Serialises line reads/writes with round-robin
//           fairness, returns read data, broadcasts an invalidation to every
//           other hart on each completed write, and owns the global AMO lock.
// Ports   : clk, rst_n            - clock, synchronous active-low reset
//           h_addr/h_rd/h_wr/
//           h_data_out           - per-hart request (level, held to h_dv)
//           h_data_in, h_dv      - read line (broadcast) and completion pulse
//           inv_addr, inv        - invalidate address and per-hart pulse
//           amo_req, amo_ack     - AMO lock request / grant (levels)
//           m_addr/m_rd/m_wr/
//           m_data_out           - memory request, held until m_dv
//           m_data_in, m_dv      - memory read line and completion pulse
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sys_bus
  import sys_bus_pkg::*;
#(
  parameter int N_HARTS = 2,
  parameter int LINE    = HMEM_LINE,
  parameter int OFFS    = HMEM_OFFS_LEN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // hart side
  input  logic [N_HARTS*64-1:0]   h_addr,
  input  logic [N_HARTS-1:0]      h_rd,
  input  logic [N_HARTS-1:0]      h_wr,
  input  logic [N_HARTS*LINE-1:0] h_data_out,
  output logic [LINE-1:0]         h_data_in,
  output logic [N_HARTS-1:0]      h_dv,
  output logic [63:0]             inv_addr,
  output logic [N_HARTS-1:0]      inv,
  input  logic [N_HARTS-1:0]      amo_req,
  output logic [N_HARTS-1:0]      amo_ack,
  // memory side
  output logic [63:0]             m_addr,
  output logic                    m_rd,
  output logic                    m_wr,
  output logic [LINE-1:0]         m_data_out,
  input  logic [LINE-1:0]         m_data_in,
  input  logic                    m_dv
);

  sb_state_t state;
  sb_state_t state_nxt;

  logic [N_HARTS-1:0] cur;        // one-hot hart of the in-flight transaction
  logic               op_wr;      // in-flight transaction is a write
  logic [N_HARTS-1:0] turn_mask;  // last-served hart, valid first IDLE only

  logic               in_idle;
  logic               lock_keep;
  logic               lock_upd;
  logic [N_HARTS-1:0] lock_gnt;
  logic [N_HARTS-1:0] owner_nxt;
  logic [N_HARTS-1:0] own_mask;
  logic [N_HARTS-1:0] bus_req;
  logic               bus_upd;
  logic [N_HARTS-1:0] bus_gnt;

  logic [63:0]        sel_addr;
  logic [LINE-1:0]    sel_data;
  logic               sel_wr;

  assign in_idle = (state == SB_IDLE);

  // ---------------------------------------------------------------------------
  // AMO lock. The current owner keeps the lock while its amo_req stays high.
  // Once it drops, the lock arbiter may hand the lock to another requester in
  // the same IDLE cycle; the resulting owner masks bus arbitration right away.
  // ---------------------------------------------------------------------------
  assign lock_keep = |(amo_ack & amo_req);
  assign lock_upd  = in_idle && !lock_keep && (|amo_req);
  assign owner_nxt = lock_keep ? amo_ack : lock_gnt;
  assign own_mask  = (|owner_nxt) ? owner_nxt : {N_HARTS{1'b1}};

  rr_arb #(
    .N      (N_HARTS)
  ) u_lock_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (amo_req),
    .update (lock_upd),
    .gnt    (lock_gnt)
  );

  // ---------------------------------------------------------------------------
  // Bus arbitration.
  // ---------------------------------------------------------------------------
  assign bus_req = (h_rd | h_wr) & own_mask & ~turn_mask;
  assign bus_upd = in_idle && (|bus_req);

  rr_arb #(
    .N      (N_HARTS)
  ) u_bus_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (bus_req),
    .update (bus_upd),
    .gnt    (bus_gnt)
  );

  // Pick the granted hart's address, write line and op. Write wins when a
  // hart raises both h_rd and h_wr.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_wr   = 1'b0;
    for (int i = 0; i < N_HARTS; i++) begin
      if (bus_gnt[i]) begin
        sel_addr = h_addr[64*i +: 64];
        sel_data = h_data_out[LINE*i +: LINE];
        sel_wr   = h_wr[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction FSM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SB_IDLE: if (|bus_gnt) state_nxt = SB_MEM;
      SB_MEM:  if (m_dv)     state_nxt = SB_RESP;
      SB_RESP:               state_nxt = SB_IDLE;
      default:               state_nxt = SB_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered datapath and outputs. h_dv / inv are launched on the m_dv edge
  // so they are visible during the RESP cycle and drop back when leaving it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur        <= '0;
      op_wr      <= 1'b0;
      turn_mask  <= '0;
      amo_ack    <= '0;
      h_dv       <= '0;
      inv        <= '0;
      inv_addr   <= '0;
      h_data_in  <= '0;
      m_addr     <= '0;
      m_data_out <= '0;
      m_rd       <= 1'b0;
      m_wr       <= 1'b0;
    end else begin
      h_dv <= '0;
      inv  <= '0;
      case (state)
        SB_IDLE: begin
          amo_ack   <= owner_nxt;
          turn_mask <= '0;
          if (|bus_gnt) begin
            cur        <= bus_gnt;
            op_wr      <= sel_wr;
            m_addr     <= line_align(sel_addr, OFFS);
            m_data_out <= sel_data;
            m_rd       <= !sel_wr;
            m_wr       <= sel_wr;
          end
        end
        SB_MEM: begin
          if (m_dv) begin
            m_rd <= 1'b0;
            m_wr <= 1'b0;
            h_dv <= cur;
            if (op_wr) begin
              inv      <= ~cur;
              inv_addr <= m_addr;
            end else begin
              h_data_in <= m_data_in;
            end
          end
        end
        SB_RESP: begin
          // The hart just served sits out the next IDLE cycle.
          turn_mask <= cur;
        end
        default: begin
          turn_mask <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sys_bus.sv
// ============================================================================
// Module  : tb_sys_bus
// Purpose : Self-checking bench for sys_bus (4 harts, 128-bit lines, 6-bit
//           line offset). A behavioural memory with programmable latency
//           answers m_rd/m_wr; expected transactions are queued when the
//           stimulus is driven and checked on the memory port and on h_dv.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sys_bus;

  localparam int N = 4;
  localparam int L = 128;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [63:0]    ha [4];
  logic [L-1:0]   hd [4];
  logic [N*64-1:0] h_addr;
  logic [N*L-1:0] h_data_out;
  logic [N-1:0]   h_rd, h_wr, amo_req;
  logic [L-1:0]   h_data_in;
  logic [N-1:0]   h_dv, inv, amo_ack;
  logic [63:0]    inv_addr, m_addr;
  logic           m_rd, m_wr, m_dv;
  logic [L-1:0]   m_data_out, m_data_in;

  assign h_addr     = {ha[3], ha[2], ha[1], ha[0]};
  assign h_data_out = {hd[3], hd[2], hd[1], hd[0]};

  sys_bus #(
    .N_HARTS    (N),
    .LINE       (L),
    .OFFS       (6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .h_addr     (h_addr),
    .h_rd       (h_rd),
    .h_wr       (h_wr),
    .h_data_out (h_data_out),
    .h_data_in  (h_data_in),
    .h_dv       (h_dv),
    .inv_addr   (inv_addr),
    .inv        (inv),
    .amo_req    (amo_req),
    .amo_ack    (amo_ack),
    .m_addr     (m_addr),
    .m_rd       (m_rd),
    .m_wr       (m_wr),
    .m_data_out (m_data_out),
    .m_data_in  (m_data_in),
    .m_dv       (m_dv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   hart;
    logic         wr;
    logic [63:0]  addr;   // expected line-aligned address
    logic [L-1:0] wdata;
    logic [3:0]   inv;
  } exp_t;

  typedef struct {
    logic [1:0]   hart;
    logic         rd;
    logic         wr;
    logic [63:0]  addr;
    logic [L-1:0] wdata;
    int           lat;
    logic [63:0]  exp_addr;
    logic         exp_wr;
    logic [3:0]   exp_inv;
  } vec_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   mem_lat = 1;
  int   mcnt = 0;
  int   rem [4];

  function automatic logic [L-1:0] pattern(input logic [63:0] a);
    pattern = {~a, a ^ 64'hA5A5_5A5A_0F0F_F0F0};
  endfunction

  task automatic chk(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: advance to the falling edge, then run memory model and monitor.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (m_dv) begin
      m_dv = 1'b0;
      mcnt = 0;
    end else if (m_rd || m_wr) begin
      if (mcnt == 0) begin
        chk("mem_req_present", L'(sb.size() != 0), L'(1));
        if (sb.size() != 0) begin
          e = sb[0];
          chk("mem_req_op", {m_rd, m_wr}, {!e.wr, e.wr});
          chk("mem_req_addr", m_addr, e.addr);
          if (e.wr) chk("mem_req_wdata", m_data_out, e.wdata);
        end
      end
      mcnt++;
      if (mcnt >= mem_lat) begin
        m_dv      = 1'b1;
        m_data_in = pattern(m_addr);
      end
    end else begin
      mcnt = 0;
    end

    if (h_dv != '0) begin
      chk("dv_expected", L'(sb.size() != 0), L'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("dv_hart", h_dv, 4'b0001 << e.hart);
        if (!e.wr) chk("rd_data", h_data_in, pattern(e.addr));
        chk("inv_vec", inv, e.inv);
        if (e.wr) chk("inv_addr", inv_addr, e.addr);
      end
      for (int i = 0; i < 4; i++) begin
        if (h_dv[i]) begin
          rem[i]--;
          if (rem[i] <= 0) begin
            h_rd[i] = 1'b0;
            h_wr[i] = 1'b0;
          end
        end
      end
    end else begin
      chk("inv_without_dv", inv, 4'b0000);
    end
  endtask

  task automatic drive(input logic [1:0] h, input logic rd, input logic wr,
                       input logic [63:0] a, input logic [L-1:0] d, input int n);
    ha[h]   = a;
    hd[h]   = d;
    h_rd[h] = rd;
    h_wr[h] = wr;
    rem[h]  = n;
  endtask

  task automatic push(input logic [1:0] h, input logic wr, input logic [63:0] ea,
                      input logic [L-1:0] d, input logic [3:0] einv);
    exp_t e;
    e.hart = h; e.wr = wr; e.addr = ea; e.wdata = d; e.inv = einv;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", L'(sb.size()), L'(0));
    if (sb.size() != 0) begin
      sb.delete();
      h_rd = '0;
      h_wr = '0;
    end
    tick();
    tick();
  endtask

  // Read with one-cycle memory latency: h_dv must appear two cycles after
  // the request is seen in IDLE.
  task automatic timed_read(input logic [1:0] h, input logic [63:0] a, input logic [63:0] ea);
    mem_lat = 1;
    drive(h, 1'b1, 1'b0, a, '0, 1);
    push(h, 1'b0, ea, '0, 4'b0000);
    tick();
    chk("lat_m_rd", L'(m_rd), L'(1));
    tick();
    chk("lat_h_dv", h_dv, 4'b0001 << h);
    drain(50);
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{2'd0, 1'b1, 1'b0, 64'h1008, '0, 2, 64'h1000, 1'b0, 4'b0000};
    vecs[1] = '{2'd1, 1'b0, 1'b1, 64'h2040, {4{32'hCAFE_0001}}, 2, 64'h2040, 1'b1, 4'b1101};
    vecs[2] = '{2'd0, 1'b1, 1'b1, 64'h3FFF, {4{32'h1234_5678}}, 1, 64'h3FC0, 1'b1, 4'b1110};
    vecs[3] = '{2'd3, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, '0, 3, 64'hFFFF_FFFF_FFFF_FFC0, 1'b0, 4'b0000};
    vecs[4] = '{2'd2, 1'b0, 1'b1, 64'h7F, {4{32'h0BAD_F00D}}, 4, 64'h40, 1'b1, 4'b1011};
    vecs[5] = '{2'd3, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_1234, {4{32'h5A5A_A5A5}}, 1, 64'hDEAD_BEEF_0000_1200, 1'b1, 4'b0111};

    rst_n = 1'b0; h_rd = '0; h_wr = '0; amo_req = '0;
    m_dv = 1'b0; m_data_in = '0;
    for (int i = 0; i < 4; i++) begin ha[i] = '0; hd[i] = '0; rem[i] = 0; end

    // Reset state
    repeat (3) tick();
    chk("rst_h_dv", h_dv, 4'b0);
    chk("rst_inv", inv, 4'b0);
    chk("rst_amo_ack", amo_ack, 4'b0);
    chk("rst_m_rd_wr", {m_rd, m_wr}, 2'b00);
    chk("rst_m_addr", m_addr, 64'h0);
    chk("rst_inv_addr", inv_addr, 64'h0);
    chk("rst_h_data_in", h_data_in, '0);
    chk("rst_m_data_out", m_data_out, '0);
    rst_n = 1'b1;
    tick();

    // Harts 0 and 1 read continuously: grants alternate 0,1,0,1.
    mem_lat = 2;
    drive(2'd0, 1'b1, 1'b0, 64'h0100, '0, 2);
    drive(2'd1, 1'b1, 1'b0, 64'h0247, '0, 2);
    push(2'd0, 1'b0, 64'h0100, '0, 4'b0000);
    push(2'd1, 1'b0, 64'h0240, '0, 4'b0000);
    push(2'd0, 1'b0, 64'h0100, '0, 4'b0000);
    push(2'd1, 1'b0, 64'h0240, '0, 4'b0000);
    drain(200);

    // Single-hart transactions from the table.
    for (int v = 0; v < 6; v++) begin
      mem_lat = vecs[v].lat;
      drive(vecs[v].hart, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, 1);
      push(vecs[v].hart, vecs[v].exp_wr, vecs[v].exp_addr, vecs[v].wdata, vecs[v].exp_inv);
      drain(100);
    end

    // Minimum latency.
    timed_read(2'd1, 64'h5555, 64'h5540);

    // AMO lock: hart0 owns the bus lock, hart1's read waits until release.
    mem_lat = 1;
    amo_req = 4'b0001;
    drive(2'd1, 1'b1, 1'b0, 64'h6000, '0, 1);
    push(2'd1, 1'b0, 64'h6000, '0, 4'b0000);
    tick();
    chk("amo_ack_grant", amo_ack, 4'b0001);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("amo_starve", {m_rd, m_wr}, 2'b00);
    end
    chk("amo_pending", L'(sb.size()), L'(1));
    amo_req = 4'b0000;
    tick();
    chk("amo_release", amo_ack, 4'b0000);
    chk("amo_served", L'(m_rd), L'(1));
    drain(50);

    // Reset while in MEM with the lock held.
    mem_lat = 20;
    amo_req = 4'b0100;
    drive(2'd2, 1'b1, 1'b0, 64'h8000, '0, 1);
    push(2'd2, 1'b0, 64'h8000, '0, 4'b0000);
    tick();
    chk("mid_amo_ack", amo_ack, 4'b0100);
    chk("mid_m_rd", L'(m_rd), L'(1));
    tick();
    rst_n = 1'b0; h_rd = '0; amo_req = '0;
    tick();
    chk("rst_mem_m_rd_wr", {m_rd, m_wr}, 2'b00);
    chk("rst_mem_h_dv", h_dv, 4'b0);
    chk("rst_mem_amo_ack", amo_ack, 4'b0);
    sb.delete();
    rst_n = 1'b1;
    tick();
    timed_read(2'd0, 64'h9010, 64'h9000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
